// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
//   SEG_TABLE  : nibble -> active-high segment pattern (bits 6..0)
//   seg_decode : table lookup on one hex nibble
//   SLOT_DEAD  : slot cycle during which every digit select is held off
//   BRIGHT_W   : width of the PWM brightness level
package sevenseg_pkg;

    localparam int unsigned BRIGHT_W  = 3;
    localparam int unsigned SLOT_DEAD = 0;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h7d, 7'h60, 7'h3e, 7'h7a, 7'h63, 7'h5b, 7'h5f, 7'h70,
        7'h7f, 7'h7b, 7'h77, 7'h4f, 7'h1d, 7'h6e, 7'h1f, 7'h17
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational hex-nibble to seven-segment pattern decoder.
//   nibble  : hex digit to show
//   pattern : active-high segment pattern, bit 6..0
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = seg_decode(nibble);
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed driver for an N-digit common-segment seven-segment display.
// Register-side writes land in a pending buffer and move to the active buffer only at
// the end of a frame, so a frame never mixes old and new data.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : one-cycle strobe capturing value/dp/blank_mask/lz_suppress
//   value        : packed hex nibbles, digit i = value[4i+3:4i]
//   dp           : decimal point per digit
//   blank_mask   : per-digit force-dark
//   lz_suppress  : enable leading-zero suppression
//   brightness   : live PWM level, 7 = full on
//   segments     : segment pattern, active-high
//   seg_dp       : decimal-point segment, active-high
//   digit_en     : one-hot digit select, active-high
//   frame_tick   : one-cycle pulse at each frame commit
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV_BITS   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [NUM_DIGITS*4-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              segments,
    output logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_tick
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_BITS-1:0] CTR_LAST = '1;
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_BITS-1:0] ctr_q;
    logic [IDX_W-1:0]    idx_q;
    logic                slot_end;
    logic                commit;

    logic [NUM_DIGITS*4-1:0] pend_value_q, act_value_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
    logic [NUM_DIGITS-1:0]   pend_blank_q, act_blank_q;
    logic                    pend_lz_q, act_lz_q;

    logic [NUM_DIGITS-1:0] supp;
    logic [NUM_DIGITS-1:0] sel;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_dark;
    logic [6:0]            cur_pattern;
    logic                  pwm_on;

    logic [6:0]            segments_d;
    logic                  seg_dp_d;
    logic [NUM_DIGITS-1:0] digit_en_d;

    assign slot_end = (ctr_q == CTR_LAST);
    assign commit   = slot_end && (idx_q == IDX_LAST);

    // Slot counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q <= '0;
            idx_q <= '0;
        end else begin
            ctr_q <= ctr_q + 1'b1;
            if (slot_end) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
        end
    end

    // Double buffer; a load on the commit cycle bypasses pending straight to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            pend_lz_q    <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            act_lz_q     <= 1'b0;
        end else begin
            if (load) begin
                pend_value_q <= value;
                pend_dp_q    <= dp;
                pend_blank_q <= blank_mask;
                pend_lz_q    <= lz_suppress;
            end
            if (commit) begin
                act_value_q <= load ? value       : pend_value_q;
                act_dp_q    <= load ? dp          : pend_dp_q;
                act_blank_q <= load ? blank_mask  : pend_blank_q;
                act_lz_q    <= load ? lz_suppress : pend_lz_q;
            end
        end
    end

    // Suppression runs from the most significant digit down and stops at the first
    // digit with a nonzero nibble or a lit dp; digit 0 never enters the chain.
    // blank_mask plays no part here, so a blank zero digit keeps the chain going.
    always_comb begin
        logic chain;
        supp  = '0;
        chain = act_lz_q;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            chain   = chain && (act_value_q[i*4 +: 4] == 4'h0) && !act_dp_q[i];
            supp[i] = chain;
        end
    end

    // Current-digit mux.
    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        sel      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib  = act_value_q[i*4 +: 4];
                cur_dp   = act_dp_q[i];
                cur_dark = act_blank_q[i] || supp[i];
                sel[i]   = 1'b1;
            end
        end
    end

    sevenseg_decode u_decode (
        .nibble  (cur_nib),
        .pattern (cur_pattern)
    );

    // Top three counter bits form the PWM phase; slot cycle 0 is dead time.
    always_comb begin
        pwm_on     = (ctr_q != DIV_BITS'(SLOT_DEAD)) &&
                     (ctr_q[DIV_BITS-1 -: BRIGHT_W] <= brightness);
        segments_d = cur_dark ? 7'h00 : cur_pattern;
        seg_dp_d   = !cur_dark && cur_dp;
        digit_en_d = (pwm_on && !cur_dark) ? sel : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments   <= '0;
            seg_dp     <= 1'b0;
            digit_en   <= '0;
            frame_tick <= 1'b0;
        end else begin
            segments   <= segments_d;
            seg_dp     <= seg_dp_d;
            digit_en   <= digit_en_d;
            frame_tick <= commit;
        end
    end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
Time-multiplexed driver for an N-digit common-segment seven-segment display.
- Takes a packed hex value, per-digit decimal points and per-digit blank mask from the register side.
- Scans one digit at a time, with tear-free double-buffered updates, leading-zero suppression, 8-level PWM brightness and anti-ghosting dead time.
- Sits between the CPU/register block and the board's display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (1..8); digit 0 is rightmost / least significant.
- DIV_BITS, 10: log2 of clocks per digit slot (minimum 3); slot length S = 2^DIV_BITS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- load  in  1  one-cycle strobe; captures value/dp/blank_mask/lz_suppress into the pending buffer
- value  in  NUM_DIGITS*4  hex nibbles; digit i = value[4i+3:4i]
- dp  in  NUM_DIGITS  decimal point per digit
- blank_mask  in  NUM_DIGITS  1 = digit forced dark
- lz_suppress  in  1  enable leading-zero suppression
- brightness  in  3  PWM level, 7 = full on; sampled live, not buffered
- segments  out  7  segment pattern, active-high
- seg_dp  out  1  decimal-point segment, active-high
- digit_en  out  NUM_DIGITS  one-hot digit select, active-high
- frame_tick  out  1  one-cycle pulse at each frame commit

Behaviour:
- Reset (async assert, release on clk):
  - pending and active buffers: value 0, dp 0, lz 0, blank_mask all ones.
  - slot counter ctr = 0, digit index idx = 0.
  - All outputs 0.
- Scan timing:
  - ctr increments every clk. When ctr == S-1 it wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
  - Frame = NUM_DIGITS*S cycles.
- Commit:
  - On the cycle ctr==S-1 and idx==NUM_DIGITS-1, active <= pending, and frame_tick is registered high for exactly one cycle.
  - A load on that same cycle is committed directly (bypass).
  - A load at any other time only updates pending. Multiple loads within a frame: last one wins.
- Outputs are registered, computed from the current ctr/idx/active/brightness, so they lag state by 1 cycle.
- Anti-ghost: when ctr == 0, digit_en = 0. segments/seg_dp carry the new digit's pattern from this point.
- PWM: digit_en[idx] = 1 when ctr != 0, ctr[DIV_BITS-1:DIV_BITS-3] <= brightness, and the digit is not dark. Otherwise all digit_en = 0.
- Dark digit: blank_mask[idx]=1, or the digit is lz-suppressed. While dark: segments = 0, seg_dp = 0, digit_en = 0.
- Leading-zero suppression (active.lz=1):
  - Digit i>0 is suppressed iff its nibble == 0, its dp == 0, and every higher digit is also suppressed.
  - Digit 0 is never suppressed.
  - A blank_mask digit does not break a suppression chain only if its nibble is 0 and its dp is 0.
- Segment encoding (bit 6..0), nibble -> hex:
  - 0:7d 1:60 2:3e 3:7a 4:63 5:5b 6:5f 7:70
  - 8:7f 9:7b A:77 b:4f C:1d d:6e E:1f F:17
- seg_dp = active.dp[idx] when not dark.
- brightness changes take effect on the next cycle, mid-slot allowed.
- Reset mid-frame: all outputs drop to 0 immediately (async). The scan restarts at idx 0 after release.

Decomposition:
- sevenseg_pkg:
  - the 16-entry encoding constant table and a decode function
  - SLOT_DEAD = 0 constant
  - brightness width constant (3)
- One natural sub-module: sevenseg_decode, purely combinational, nibble -> 7-bit pattern.
  - Instantiated once on the muxed active nibble.
- Main module holds the counters, the buffers, suppression logic and the output registers.

Test Plan:
- NUM_DIGITS=4, DIV_BITS=3; after reset, no load for 64 cycles -> digit_en=0, segments=0 throughout; frame_tick every 32 cycles.
- load value=16'h12AF, dp=0, mask=0, brightness=7, mid-frame -> old (dark) display until commit. Following frame shows:
  - digit0 segments 17
  - digit1 77
  - digit2 3e
  - digit3 60
  - Each digit_en high 7 of 8 slot cycles (cycle 0 dead).
- value=16'h0050, lz=1, dp=0 -> digits 3,2 dark, digit1 shows 5b, digit0 shows 7d. Then dp=4'b0100 -> digit2 shows 7d with seg_dp=1, digit3 dark.
- brightness=3 on value 16'h8888 -> each digit_en high for slot cycles 1..3 only. brightness=0 -> never high (ctr 0 is dead, and no other cycle qualifies).
- Two loads in one frame (16'h1111 then 16'h2222), plus a load exactly on the commit cycle in the next frame (16'h3333):
  - the first commit shows 2222 (never 1111)
  - the next commit shows 3333.
- Assert rst_n low mid-slot with digit_en active -> all outputs 0 in the same cycle. After release, scan restarts at digit0 and the display stays dark (mask all ones).
